// File: rtl/circuit_f1_pkg.sv
// Shared types and constants for the circuit_f1 three-input function block.
package circuit_f1_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned TT_W   = 8;

  // Default table: A selects B, else C.
  localparam logic [TT_W-1:0] F1_MUX = 8'hCA;

  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/circuit_f1_lut3.sv
// Pure combinational 8-entry truth-table lookup indexed by a 3-bit code.
module circuit_f1_lut3
  import circuit_f1_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = F1_MUX
) (
  input  code_t code,
  output logic  f
);

  assign f = TRUTH_TABLE[code];

endmodule

// File: rtl/circuit_f1.sv
// Three-input Boolean function with a registered copy, aligned input code and change pulse.
module circuit_f1
  import circuit_f1_pkg::*;
#(
  parameter logic [TT_W-1:0] TRUTH_TABLE = F1_MUX,
  parameter logic            RESET_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  output logic              f1,
  output logic              f1_q,
  output logic [CODE_W-1:0] code_q,
  output logic              changed
);

  code_t code;

  assign code = {a, b, c};

  circuit_f1_lut3 #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut3 (
    .code(code),
    .f   (f1)
  );

  // changed compares the incoming value with the value being replaced, so it rises with f1_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_q    <= RESET_VAL;
      code_q  <= CODE_W'(0);
      changed <= 1'b0;
    end else begin
      f1_q    <= f1;
      code_q  <= code;
      changed <= (f1 != f1_q);
    end
  end

endmodule

// File: tb/tb_circuit_f1.sv
// Directed self-checking bench for circuit_f1 (default mux table and an XOR-table instance).
module tb_circuit_f1;

  logic       clk;
  logic       rst_n;
  logic       a, b, c;
  logic       f1, f1_q, changed;
  logic [2:0] code_q;
  logic       x_f1, x_f1_q, x_changed;
  logic [2:0] x_code_q;

  int vectors;
  int miscompares;

  logic exp_mux [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic exp_xor [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  circuit_f1 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c      (c),
    .f1     (f1),
    .f1_q   (f1_q),
    .code_q (code_q),
    .changed(changed)
  );

  circuit_f1 #(
    .TRUTH_TABLE(8'h96),
    .RESET_VAL  (1'b0)
  ) dut_xor (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c      (c),
    .f1     (x_f1),
    .f1_q   (x_f1_q),
    .code_q (x_code_q),
    .changed(x_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_code(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_code(3'b000);
    #2;
    vectors++;
    if (f1_q !== 1'b0) begin
      miscompares++; $display("FAIL reset_f1_q: got %b want 0", f1_q);
    end
    vectors++;
    if (code_q !== 3'b000) begin
      miscompares++; $display("FAIL reset_code_q: got %b want 000", code_q);
    end
    vectors++;
    if (changed !== 1'b0) begin
      miscompares++; $display("FAIL reset_changed: got %b want 0", changed);
    end
  endtask

  // Combinational path checked while reset is held, so f1 must not depend on rst_n.
  task automatic test_comb_sweep();
    for (int i = 0; i < 8; i++) begin
      set_code(3'(i));
      #1;
      vectors++;
      if (f1 !== exp_mux[i]) begin
        miscompares++; $display("FAIL comb_mux code=%0d: got %b want %b", i, f1, exp_mux[i]);
      end
      vectors++;
      if (x_f1 !== exp_xor[i]) begin
        miscompares++; $display("FAIL comb_xor code=%0d: got %b want %b", i, x_f1, exp_xor[i]);
      end
      #9;
    end
  endtask

  task automatic test_registered_sweep();
    logic prev, xprev;
    prev  = 1'b0;
    xprev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_code(3'(i));
      tick();
      vectors++;
      if (f1_q !== exp_mux[i]) begin
        miscompares++; $display("FAIL reg_f1_q code=%0d: got %b want %b", i, f1_q, exp_mux[i]);
      end
      vectors++;
      if (code_q !== 3'(i)) begin
        miscompares++; $display("FAIL reg_code_q: got %b want %b", code_q, 3'(i));
      end
      vectors++;
      if (changed !== (exp_mux[i] ^ prev)) begin
        miscompares++; $display("FAIL reg_changed code=%0d: got %b want %b", i, changed, exp_mux[i] ^ prev);
      end
      vectors++;
      if (x_f1_q !== exp_xor[i] || x_changed !== (exp_xor[i] ^ xprev)) begin
        miscompares++;
        $display("FAIL reg_xor code=%0d: got f1_q=%b changed=%b want f1_q=%b changed=%b",
                 i, x_f1_q, x_changed, exp_xor[i], exp_xor[i] ^ xprev);
      end
      prev  = exp_mux[i];
      xprev = exp_xor[i];
    end
  endtask

  task automatic test_change_pulse();
    set_code(3'b000);
    tick();
    tick();
    vectors++;
    if (f1_q !== 1'b0 || changed !== 1'b0) begin
      miscompares++; $display("FAIL pulse_idle: got f1_q=%b changed=%b want 0 0", f1_q, changed);
    end
    set_code(3'b001);
    tick();
    vectors++;
    if (f1_q !== 1'b1 || changed !== 1'b1) begin
      miscompares++; $display("FAIL pulse_rise: got f1_q=%b changed=%b want 1 1", f1_q, changed);
    end
    tick();
    vectors++;
    if (f1_q !== 1'b1 || changed !== 1'b0) begin
      miscompares++; $display("FAIL pulse_fall: got f1_q=%b changed=%b want 1 0", f1_q, changed);
    end
  endtask

  task automatic test_async_reset();
    set_code(3'b111);
    tick();
    vectors++;
    if (f1_q !== 1'b1) begin
      miscompares++; $display("FAIL async_pre_f1_q: got %b want 1", f1_q);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (f1_q !== 1'b0 || code_q !== 3'b000 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear: got f1_q=%b code_q=%b changed=%b want 0 000 0", f1_q, code_q, changed);
    end
    vectors++;
    if (f1 !== 1'b1) begin
      miscompares++; $display("FAIL async_f1_tracks: got %b want 1", f1);
    end
  endtask

  task automatic test_reset_release();
    set_code(3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (f1_q !== 1'b1 || code_q !== 3'b110 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL release: got f1_q=%b code_q=%b changed=%b want 1 110 1", f1_q, code_q, changed);
    end
    vectors++;
    if (x_f1_q !== 1'b0 || x_code_q !== 3'b110 || x_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL release_xor: got f1_q=%b code_q=%b changed=%b want 0 110 0", x_f1_q, x_code_q, x_changed);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_comb_sweep();
    test_registered_sweep();
    test_change_pulse();
    test_async_reset();
    test_reset_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
